maze_player_ctrl: RTL and testbench

Player-movement controller that sits directly downstream of the maze carver. It waits for the carver's `finish`, then turns four raw push-buttons into debounced single-step moves across the 16×16 carved bitmap `maze_data`. A move is accepted only onto carved (path) cells. The block tracks a move count and flags `won` when the player reaches a goal cell; the display stage consumes its position and status outputs.

---
 rtl/maze_player_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_maze_player_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maze_player_ctrl
// Brief    : Debounced push-button player movement across a carved 16x16 maze,
//            with move counting and goal detection.
// Revision : 1.0 - initial release
// ============================================================================
module maze_player_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int START_X   = 4,
    parameter int START_Y   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         maze_ready,
    input  logic [255:0] maze_data,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [3:0]   goal_x,
    input  logic [3:0]   goal_y,
    output logic [3:0]   player_x,
    output logic [3:0]   player_y,
    output logic [9:0]   move_count,
    output logic         move_pulse,
    output logic         won
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_PLAY = 2'd1;
    localparam logic [1:0]  S_WON  = 2'd2;

    localparam logic [15:0] c_db_last = 16'(DB_CYCLES - 1);
    localparam logic [3:0]  c_start_x = 4'(START_X);
    localparam logic [3:0]  c_start_y = 4'(START_Y);
    localparam logic [9:0]  c_cnt_max = 10'd1023;

    // Button index order: 3 = up, 2 = down, 1 = left, 0 = right
    logic [3:0] w_btn;
    logic [3:0] w_evt;

    assign w_btn = {btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic        r_s1;
        logic        r_s2;
        logic        r_db;
        logic        r_db_q;
        logic [15:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_db   <= 1'b0;
                r_db_q <= 1'b0;
                r_cnt  <= 16'd0;
            end else begin
                r_s1   <= w_btn[i];
                r_s2   <= r_s1;
                r_db_q <= r_db;
                if (r_s2 == r_db) begin
                    r_cnt <= 16'd0;
                end else if (r_cnt == c_db_last) begin
                    r_db  <= r_s2;
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end

        assign w_evt[i] = r_db & ~r_db_q;
    end

    logic [1:0] r_state;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [9:0] r_count;
    logic       r_move_pulse;
    logic       r_won;

    logic [3:0] w_tx;
    logic [3:0] w_ty;
    logic       w_try;
    logic       w_ok;

    // The highest-priority event claims the cycle even if its move is rejected
    always_comb begin
        w_tx  = r_x;
        w_ty  = r_y;
        w_try = 1'b0;
        if (w_evt[3]) begin
            if (r_y != 4'd0) begin
                w_ty  = r_y - 4'd1;
                w_try = 1'b1;
            end
        end else if (w_evt[2]) begin
            if (r_y != 4'd15) begin
                w_ty  = r_y + 4'd1;
                w_try = 1'b1;
            end
        end else if (w_evt[1]) begin
            if (r_x != 4'd0) begin
                w_tx  = r_x - 4'd1;
                w_try = 1'b1;
            end
        end else if (w_evt[0]) begin
            if (r_x != 4'd15) begin
                w_tx  = r_x + 4'd1;
                w_try = 1'b1;
            end
        end
    end

    assign w_ok = w_try & maze_data[{w_ty, w_tx}];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= c_start_x;
            r_y          <= c_start_y;
            r_count      <= 10'd0;
            r_move_pulse <= 1'b0;
            r_won        <= 1'b0;
        end else begin
            r_move_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_x     <= c_start_x;
                    r_y     <= c_start_y;
                    r_count <= 10'd0;
                    r_won   <= 1'b0;
                    if (maze_ready) begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!maze_ready) begin
                        r_state <= S_IDLE;
                        r_x     <= c_start_x;
                        r_y     <= c_start_y;
                        r_count <= 10'd0;
                        r_won   <= 1'b0;
                    end else if (r_x == goal_x && r_y == goal_y) begin
                        r_state <= S_WON;
                        r_won   <= 1'b1;
                    end else if (w_ok) begin
                        r_x          <= w_tx;
                        r_y          <= w_ty;
                        r_move_pulse <= 1'b1;
                        if (r_count != c_cnt_max) begin
                            r_count <= r_count + 10'd1;
                        end
                    end
                end
                S_WON: begin
                    if (!maze_ready) begin
                        r_state <= S_IDLE;
                        r_x     <= c_start_x;
                        r_y     <= c_start_y;
                        r_count <= 10'd0;
                        r_won   <= 1'b0;
                    end else begin
                        r_won <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign player_x   = r_x;
    assign player_y   = r_y;
    assign move_count = r_count;
    assign move_pulse = r_move_pulse;
    assign won        = r_won;

endmodule
`default_nettype wire

// File: tb/tb_maze_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_player_ctrl
// Brief    : Directed self-checking bench for maze_player_ctrl (DB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_player_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         maze_ready;
    logic [255:0] maze;
    logic         btn_up, btn_down, btn_left, btn_right;
    logic [3:0]   goal_x, goal_y;
    logic [3:0]   player_x, player_y;
    logic [9:0]   move_count;
    logic         move_pulse;
    logic         won;

    int n_pass  = 0;
    int n_total = 0;

    maze_player_ctrl #(.DB_CYCLES(4), .START_X(4), .START_Y(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .maze_ready (maze_ready),
        .maze_data  (maze),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .player_x   (player_x),
        .player_y   (player_y),
        .move_count (move_count),
        .move_pulse (move_pulse),
        .won        (won)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up    = v;
            1: btn_down  = v;
            2: btn_left  = v;
            default: btn_right = v;
        endcase
    endtask

    // Hold a button long enough to register, release, let it settle; count strobes seen
    task automatic press(input int b, output int pulses);
        pulses = 0;
        set_btn(b, 1'b1);
        repeat (12) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
        set_btn(b, 1'b0);
        repeat (10) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        int pulses;
        reset = 1'b1; maze_ready = 1'b0;
        btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        n_total++;
        if (player_x !== 4'd4 || player_y !== 4'd4) $display("FAIL reset_pos: got (%0d,%0d) want (4,4)", player_x, player_y);
        else n_pass++;
        n_total++;
        if (move_count !== 10'd0) $display("FAIL reset_count: got %0d want 0", move_count);
        else n_pass++;
        n_total++;
        if (won !== 1'b0 || move_pulse !== 1'b0) $display("FAIL reset_flags: got won=%b pulse=%b want 0 0", won, move_pulse);
        else n_pass++;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
        pulses = 0;
        repeat (20) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
        n_total++;
        if (player_x !== 4'd4 || pulses != 0) $display("FAIL idle_ignore: got x=%0d pulses=%0d want x=4 pulses=0", player_x, pulses);
        else n_pass++;
        btn_right = 1'b0;
        step(10);
    endtask

    task automatic test_debounce_latency;
        int early;
        int pulses;
        maze_ready = 1'b1;
        step(1);
        btn_right = 1'b1;
        early = 0;
        repeat (6) begin
            step(1);
            if (move_pulse !== 1'b0 || player_x !== 4'd4) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL db_early: got %0d early cycles want 0", early);
        else n_pass++;
        step(1);
        n_total++;
        if (player_x !== 4'd5 || move_pulse !== 1'b1) $display("FAIL db_edge7: got x=%0d pulse=%b want x=5 pulse=1", player_x, move_pulse);
        else n_pass++;
        n_total++;
        if (move_count !== 10'd1) $display("FAIL db_count: got %0d want 1", move_count);
        else n_pass++;
        step(1);
        n_total++;
        if (move_pulse !== 1'b0) $display("FAIL db_pulse_width: got %b want 0", move_pulse);
        else n_pass++;
        pulses = 0;
        repeat (49) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 0 || player_x !== 4'd5) $display("FAIL db_hold: got pulses=%0d x=%0d want 0 5", pulses, player_x);
        else n_pass++;
        btn_right = 1'b0;
        step(10);
        btn_left = 1'b1;
        step(3);
        btn_left = 1'b0;
        pulses = 0;
        repeat (15) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 0 || player_x !== 4'd5) $display("FAIL db_glitch: got pulses=%0d x=%0d want 0 5", pulses, player_x);
        else n_pass++;
    endtask

    task automatic test_wall_edge;
        int pulses;
        int total;
        press(2, pulses);
        n_total++;
        if (pulses != 1 || player_x !== 4'd4 || move_count !== 10'd2) $display("FAIL left_move: got pulses=%0d x=%0d cnt=%0d want 1 4 2", pulses, player_x, move_count);
        else n_pass++;
        press(0, pulses);
        n_total++;
        if (pulses != 0 || player_y !== 4'd4 || move_count !== 10'd2) $display("FAIL wall_up: got pulses=%0d y=%0d cnt=%0d want 0 4 2", pulses, player_y, move_count);
        else n_pass++;
        total = 0;
        repeat (11) begin
            press(3, pulses);
            total += pulses;
        end
        n_total++;
        if (total != 11 || player_x !== 4'd15 || move_count !== 10'd13) $display("FAIL walk_right: got pulses=%0d x=%0d cnt=%0d want 11 15 13", total, player_x, move_count);
        else n_pass++;
        press(3, pulses);
        n_total++;
        if (pulses != 0 || player_x !== 4'd15 || move_count !== 10'd13) $display("FAIL edge_right: got pulses=%0d x=%0d cnt=%0d want 0 15 13", pulses, player_x, move_count);
        else n_pass++;
        repeat (11) press(2, pulses);
        n_total++;
        if (player_x !== 4'd4 || move_count !== 10'd24) $display("FAIL walk_left: got x=%0d cnt=%0d want 4 24", player_x, move_count);
        else n_pass++;
    endtask

    task automatic test_priority;
        int pulses;
        maze[4 + 16*3] = 1'b1;
        maze[3 + 16*4] = 1'b1;
        btn_up = 1'b1; btn_left = 1'b1;
        pulses = 0;
        repeat (12) begin
            step(1);
            if (move_pulse === 1'b1) pulses++;
        end
        btn_up = 1'b0; btn_left = 1'b0;
        step(10);
        n_total++;
        if (pulses != 1 || player_x !== 4'd4 || player_y !== 4'd3) $display("FAIL prio_pos: got pulses=%0d (%0d,%0d) want 1 (4,3)", pulses, player_x, player_y);
        else n_pass++;
        n_total++;
        if (move_count !== 10'd25) $display("FAIL prio_count: got %0d want 25", move_count);
        else n_pass++;
        press(1, pulses);
        n_total++;
        if (player_y !== 4'd4 || move_count !== 10'd26) $display("FAIL down_move: got y=%0d cnt=%0d want 4 26", player_y, move_count);
        else n_pass++;
    endtask

    task automatic test_win;
        int pulses;
        goal_x = 4'd5; goal_y = 4'd4;
        btn_right = 1'b1;
        step(7);
        n_total++;
        if (player_x !== 4'd5 || won !== 1'b0) $display("FAIL win_move: got x=%0d won=%b want 5 0", player_x, won);
        else n_pass++;
        step(1);
        n_total++;
        if (won !== 1'b1) $display("FAIL win_flag: got %b want 1", won);
        else n_pass++;
        btn_right = 1'b0;
        step(10);
        press(2, pulses);
        n_total++;
        if (pulses != 0 || player_x !== 4'd5 || won !== 1'b1 || move_count !== 10'd27) $display("FAIL win_frozen: got pulses=%0d x=%0d won=%b cnt=%0d want 0 5 1 27", pulses, player_x, won, move_count);
        else n_pass++;
    endtask

    task automatic test_restart;
        maze_ready = 1'b0;
        goal_x = 4'd4; goal_y = 4'd4;
        step(1);
        n_total++;
        if (player_x !== 4'd4 || player_y !== 4'd4 || move_count !== 10'd0 || won !== 1'b0) $display("FAIL restart: got (%0d,%0d) cnt=%0d won=%b want (4,4) 0 0", player_x, player_y, move_count, won);
        else n_pass++;
        maze_ready = 1'b1;
        step(1);
        n_total++;
        if (won !== 1'b0) $display("FAIL replay_entry: got won=%b want 0", won);
        else n_pass++;
        // start cell equals goal: the first PLAY edge enters WON
        step(1);
        n_total++;
        if (won !== 1'b1) $display("FAIL start_is_goal: got won=%b want 1", won);
        else n_pass++;
    endtask

    initial begin
        maze = '0;
        for (int x = 0; x < 16; x++) maze[x + 16*4] = 1'b1;
        goal_x = 4'd0; goal_y = 4'd0;
        test_reset;
        test_debounce_latency;
        test_wall_edge;
        test_priority;
        test_win;
        test_restart;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
